rf_wb_scheduler: RTL and testbench

// - Shares the single register-file write port between two writers:
//   - the in-order pipeline writeback (WB), which cannot be back-pressured;
//   - one long-latency unit (LU, e.g. divider/load), using a valid/ready handshake.
// - Keeps a 32-entry scoreboard of LU destinations, so decode stalls on RAW/WAW hazards.
// - Forces a pipeline bubble when the LU is starved of the write port.
// - Sits between the writeback stage, the LU and the register file (rf_wr/rd/wdata).

---
 rtl/rf_wb_scheduler.sv | 154 +++++++++++++++
 tb/tb_rf_wb_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter (WB over LU) with LU destination scoreboard and starvation bubble.
// Optional RF_BYPASS_EN adds write-port-to-decode read bypass and relaxes hazard on bypassed LU sources.
module rf_wb_scheduler #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        hazard,
    output logic        pipe_stall,
    output logic        rf_wr,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata
`ifdef RF_BYPASS_EN
    ,
    input  logic [31:0] rf_rdata1_i,
    input  logic [31:0] rf_rdata2_i,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starveCnt_q, starveCnt_d;
    logic [CNT_W-1:0]   cntInc;
    logic [31:0]        busy_q, busy_d;
    logic               luXfer;

    // WB always wins the port because the pipeline cannot be stalled at writeback.
    always_comb begin
        rf_wr    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        lu_ready = 1'b0;
        if (!rst) begin
            if (wb_valid) begin
                rf_wr    = 1'b1;
                rf_rd    = wb_rd;
                rf_wdata = wb_wdata;
            end else if (lu_valid) begin
                rf_wr    = 1'b1;
                rf_rd    = lu_rd;
                rf_wdata = lu_wdata;
                lu_ready = 1'b1;
            end
        end
    end

    assign luXfer = lu_valid & lu_ready;

    always_comb begin
        busy_d = busy_q;
        if (luXfer) begin
            busy_d[lu_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        cntInc      = (starveCnt_q == CNT_MAX) ? starveCnt_q : starveCnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (lu_valid && !lu_ready) begin
                    state_d     = WAIT;
                    starveCnt_d = CNT_W'(1);
                end
            end
            WAIT: begin
                if (luXfer) begin
                    state_d     = IDLE;
                    starveCnt_d = '0;
                end else begin
                    starveCnt_d = cntInc;
                    if (starveCnt_q >= STARVE_LAST) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                if (luXfer) begin
                    state_d     = IDLE;
                    starveCnt_d = '0;
                end else begin
                    starveCnt_d = cntInc;
                end
            end
            default: begin
                state_d     = IDLE;
                starveCnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starveCnt_q <= '0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            busy_q      <= busy_d;
        end
    end

    assign pipe_stall = (state_q == FORCE) && !rst;

`ifdef RF_BYPASS_EN
    logic byp1, byp2;

    // A source fed straight from this cycle's LU write no longer needs to wait on its busy bit.
    always_comb begin
        byp1   = rf_wr && (rf_rd == dec_rs1) && (dec_rs1 != 5'd0);
        byp2   = rf_wr && (rf_rd == dec_rs2) && (dec_rs2 != 5'd0);
        rdata1 = byp1 ? rf_wdata : rf_rdata1_i;
        rdata2 = byp2 ? rf_wdata : rf_rdata2_i;
        hazard = !rst && ((busy_q[dec_rs1] && !(byp1 && lu_ready)) ||
                          (busy_q[dec_rs2] && !(byp2 && lu_ready)) ||
                          busy_q[dec_rd]);
    end
`else
    assign hazard = !rst && (busy_q[dec_rs1] || busy_q[dec_rs2] || busy_q[dec_rd]);
`endif

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (rst)
        (iss_valid && (iss_rd != 5'd0)) |-> !busy_q[iss_rd]);
    assert property (@(posedge clk) disable iff (rst)
        (lu_valid && !lu_ready) |=> lu_valid);
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: directed vectors push expectations, a negedge monitor checks them.
module tb_rf_wb_scheduler;

    logic        clock;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic        pipe_stall;
    logic        rf_wr;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
`ifdef RF_BYPASS_EN
    logic [31:0] rdata1, rdata2;
`endif

    typedef struct {
        string       name;
        logic [5:0]  mask;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        rdy;
        logic        hz;
        logic        ps;
    } exp_t;

    localparam logic [5:0] ALL = 6'h3F;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    rf_wb_scheduler #(.STARVE_MAX(4), .CNT_W(4)) dut (
        .clk(clock), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wdata(lu_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard(hazard), .pipe_stall(pipe_stall),
        .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
`ifdef RF_BYPASS_EN
        , .rf_rdata1_i(32'h0), .rf_rdata2_i(32'h0), .rdata1(rdata1), .rdata2(rdata2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs just after the active edge.
    task automatic applyStimulus(input logic r, input logic wbV, input logic [4:0] wbRd,
                                 input logic [31:0] wbD, input logic luV, input logic [4:0] luRd,
                                 input logic [31:0] luD, input logic issV, input logic [4:0] issRd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdV);
        @(posedge clock);
        #1;
        rst = r;
        wb_valid = wbV; wb_rd = wbRd; wb_wdata = wbD;
        lu_valid = luV; lu_rd = luRd; lu_wdata = luD;
        iss_valid = issV; iss_rd = issRd;
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rdV;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] mask, input logic wr,
                               input logic [4:0] rd, input logic [31:0] wd, input logic rdy,
                               input logic hz, input logic ps);
        exp_t e;
        e.name = name; e.mask = mask; e.wr = wr; e.rd = rd; e.wd = wd;
        e.rdy = rdy; e.hz = hz; e.ps = ps;
        expQ.push_back(e);
    endtask

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s %s: got 0x%0h expected 0x%0h", name, field, act, expv);
        end
    endtask

    // Monitor: outputs are compared mid-cycle against whatever the stimulus queued for that cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                if (e.mask[0]) cmp(e.name, "rf_wr",      32'(rf_wr),      32'(e.wr));
                if (e.mask[1]) cmp(e.name, "rf_rd",      32'(rf_rd),      32'(e.rd));
                if (e.mask[2]) cmp(e.name, "rf_wdata",   rf_wdata,        e.wd);
                if (e.mask[3]) cmp(e.name, "lu_ready",   32'(lu_ready),   32'(e.rdy));
                if (e.mask[4]) cmp(e.name, "hazard",     32'(hazard),     32'(e.hz));
                if (e.mask[5]) cmp(e.name, "pipe_stall", 32'(pipe_stall), 32'(e.ps));
            end
        end
    end

    initial begin
        rst = 1'b1;
        wb_valid = 0; wb_rd = 0; wb_wdata = 0;
        lu_valid = 0; lu_rd = 0; lu_wdata = 0;
        iss_valid = 0; iss_rd = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;

        applyStimulus(1, 1, 5, 32'hAAAA, 1, 7, 32'h1234, 0, 0, 0, 0, 0);
        checkOutput("rst_prio", ALL, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_state", ALL, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 5, 32'hAAAA, 1, 7, 32'h1234, 0, 0, 0, 0, 0);
        checkOutput("coll_wb", ALL, 1, 5, 32'hAAAA, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 0, 0, 0);
        checkOutput("coll_lu", ALL, 1, 7, 32'h1234, 1, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        checkOutput("iss9", ALL, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        checkOutput("hz_rs2", ALL, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 9, 0);
        checkOutput("lu_wr9", ALL, 1, 9, 32'h99, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        checkOutput("clr9", ALL, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0);
        checkOutput("iss12", ALL, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        checkOutput("hz_rd", ALL, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0);
        checkOutput("hz_rs1", ALL, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 12, 32'hC, 0, 0, 12, 0, 0);
        checkOutput("lu_wr12", ALL, 1, 12, 32'hC, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0);
        checkOutput("clr12", ALL, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 1, 3, 32'h33, 1, 3, 0, 0, 0);
        checkOutput("setwin_wr", ALL, 1, 3, 32'h33, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        checkOutput("setwin_busy", ALL, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 3, 32'h44, 0, 0, 3, 0, 0);
        checkOutput("lu_wr3", ALL, 1, 3, 32'h44, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        checkOutput("clr3", ALL, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 32'h11, 1, 20, 32'h2020, 0, 0, 0, 0, 0);
            checkOutput($sformatf("starve_w%0d", i), ALL, 1, 1, 32'h11, 0, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 1, 32'h11, 1, 20, 32'h2020, 0, 0, 0, 0, 0);
            checkOutput($sformatf("starve_f%0d", i), ALL, 1, 1, 32'h11, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0, 1, 20, 32'h2020, 0, 0, 0, 0, 0);
        checkOutput("starve_grant", ALL, 1, 20, 32'h2020, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("starve_rel", ALL, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("iss_x0", ALL, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_nohz", ALL, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_x0", ALL, 1, 0, 32'hDEAD, 0, 0, 0);

        applyStimulus(0, 1, 2, 32'h22, 1, 21, 32'h2121, 1, 30, 0, 0, 0);
        checkOutput("rs_w0", ALL, 1, 2, 32'h22, 0, 0, 0);
        applyStimulus(0, 1, 2, 32'h22, 1, 21, 32'h2121, 0, 0, 30, 0, 0);
        checkOutput("rs_w1", ALL, 1, 2, 32'h22, 0, 1, 0);
        applyStimulus(0, 1, 2, 32'h22, 1, 21, 32'h2121, 0, 0, 0, 0, 0);
        checkOutput("rs_w2", ALL, 1, 2, 32'h22, 0, 0, 0);
        applyStimulus(0, 1, 2, 32'h22, 1, 21, 32'h2121, 0, 0, 0, 0, 0);
        checkOutput("rs_w3", ALL, 1, 2, 32'h22, 0, 0, 0);
        applyStimulus(0, 1, 2, 32'h22, 1, 21, 32'h2121, 0, 0, 0, 0, 0);
        checkOutput("rs_force", ALL, 1, 2, 32'h22, 0, 0, 1);
        applyStimulus(1, 1, 2, 32'h22, 1, 21, 32'h2121, 0, 0, 30, 0, 0);
        checkOutput("rs_inrst", ALL, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 30, 0, 0);
        checkOutput("rs_after", ALL, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 22, 32'h5, 0, 0, 0, 0, 0);
        checkOutput("rs_lugrant", ALL, 1, 22, 32'h5, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_end", ALL, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clock);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
